inst_stream_issuer: RTL

- Transmitter end of the pipeline's 8-bit instruction valid/ready port. Drives `inst`/`inst_valid` and consumes `inst_ready`.
- Holds a small program RAM loaded by the bench or host. On `start`, streams `length` instructions in order and honours back-pressure.
- Sits between a test host and the pipeline core, replacing the free primary-input instruction feed for directed runs and model checking.

---
 rtl/pipe_isa_pkg.sv | 41 ++++
 rtl/inst_prog_mem.sv | 30 +++
 rtl/inst_stream_issuer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_isa_pkg
// Brief   : Shared ISA encodings, field slices and issuer FSM state type.
// Revision: 1.0  initial release
// ============================================================================
package pipe_isa_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } issue_state_t;

    function automatic logic [1:0] op_of(input logic [7:0] i);
        return i[7:6];
    endfunction

    function automatic logic [1:0] rs1_of(input logic [7:0] i);
        return i[5:4];
    endfunction

    function automatic logic [1:0] rs2_of(input logic [7:0] i);
        return i[3:2];
    endfunction

    function automatic logic [1:0] rd_of(input logic [7:0] i);
        return i[1:0];
    endfunction

    function automatic logic [3:0] imm_of(input logic [7:0] i);
        return i[5:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_prog_mem.sv
`default_nettype none
// ============================================================================
// Module  : inst_prog_mem
// Brief   : DEPTH x 8 program store, synchronous write, combinational read.
// Revision: 1.0  initial release
// ============================================================================
module inst_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/inst_stream_issuer.sv
`default_nettype none
// ============================================================================
// Module  : inst_stream_issuer
// Brief   : Streams a loaded program onto the 8-bit inst valid/ready port.
// Revision: 1.0  initial release
// ============================================================================
module inst_stream_issuer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic          start,
    input  logic [AW:0]   length,
    input  logic          flush,
    output logic [7:0]    inst,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   issued_cnt
);
    import pipe_isa_pkg::*;

    issue_state_t  r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic [AW:0]   r_len, w_len_nxt;
    logic [AW:0]   r_cnt, w_cnt_nxt;
    logic [7:0]    r_inst, w_inst_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_done, w_done_nxt;

    logic [7:0]    w_mem_data;
    logic          w_xfer;
    logic          w_last_addr;
    logic [AW:0]   w_cnt_inc;
    logic          w_prog_we;

    assign w_prog_we = prog_we && (r_state == ST_IDLE);

    inst_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (r_pc),
        .rdata (w_mem_data)
    );

    assign w_xfer      = r_valid && inst_ready;
    assign w_last_addr = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));
    // A word taken by the pipeline always counts, even in a flush cycle.
    assign w_cnt_inc   = (w_xfer && (r_cnt < r_len)) ? (r_cnt + (AW+1)'(1)) : r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_inst_nxt  = r_inst;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_len_nxt   = length;
                        w_pc_nxt    = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_cnt_nxt = w_cnt_inc;
                if (flush) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (!r_valid || w_xfer) begin
                    w_inst_nxt  = w_mem_data;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pc + AW'(1);
                    if (w_last_addr) begin
                        w_state_nxt = ST_LAST;
                    end
                end
            end
            ST_LAST: begin
                w_cnt_nxt = w_cnt_inc;
                if (flush) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_inst  <= 8'h00;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_inst  <= w_inst_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign inst       = r_inst;
    assign inst_valid = r_valid;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign issued_cnt = r_cnt;

endmodule
`default_nettype wire
